// File: rtl/spiflash_arb_pkg.sv
// Shared encodings and the round-robin pick helper for the two-port flash arbiter.
package spiflash_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_STREAM = 1'b1;

    // On a tie, grant the port that was not served last. Until the first grant completes
    // there is no history, so CPU fetch takes the first tie.
    function automatic logic pick_port(input logic req0, input logic req1,
                                       input logic last, input logic seen);
        if (req0 && req1) begin
            return seen ? ~last : PORT_CPU;
        end
        return (req1 && !req0) ? PORT_STREAM : PORT_CPU;
    endfunction

endpackage

// File: rtl/spiflash_arb_if.sv
// Request/response bundle for both arbiter ports plus the flash reader handshake.
interface spiflash_arb_if #(
    parameter int ADDR_W = 24
);
    logic              m0_valid;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_rdata;
    logic              m0_ready;

    logic              m1_valid;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_rdata;
    logic              m1_ready;

    logic              f_valid;
    logic [ADDR_W-1:0] f_addr;
    logic [31:0]       f_rdata;
    logic              f_ready;

    // Arbiter side.
    modport slave (
        input  m0_valid, m0_addr, m1_valid, m1_addr, f_rdata, f_ready,
        output m0_rdata, m0_ready, m1_rdata, m1_ready, f_valid, f_addr
    );

    // Requesters and flash reader side.
    modport master (
        output m0_valid, m0_addr, m1_valid, m1_addr, f_rdata, f_ready,
        input  m0_rdata, m0_ready, m1_rdata, m1_ready, f_valid, f_addr
    );
endinterface

// File: rtl/spiflash_lastword.sv
// One-entry cache holding the most recently fetched flash word and its address.
module spiflash_lastword #(
    parameter int ADDR_W = 24
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fill,
    input  logic              i_inv,
    input  logic              i_inv_pend,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [31:0]       i_fill_data,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [31:0]       o_data
);

    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;

    // A fill is dropped if an invalidate landed at any point during the fetch that produced it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_inv) begin
            r_vld <= 1'b0;
        end else if (i_fill && !i_inv_pend) begin
            r_vld  <= 1'b1;
            r_addr <= i_fill_addr;
            r_data <= i_fill_data;
        end
    end

    assign o_hit  = r_vld && (i_lookup_addr == r_addr) && !i_inv;
    assign o_data = r_data;

endmodule

// File: rtl/spiflash_arb.sv
// Round-robin arbiter sharing one SPI flash word reader between CPU fetch and sample streamer.
module spiflash_arb
    import spiflash_arb_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_inv,
    output logic           o_busy,
    spiflash_arb_if.slave  io_bus
);

    logic [1:0]        r_state;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rr_ptr;
    logic              r_rr_seen;
    logic              r_inv_pend;
    logic              r_m0_ready;
    logic              r_m1_ready;
    logic [31:0]       r_m0_rdata;
    logic [31:0]       r_m1_rdata;
    logic              r_f_valid;
    logic [ADDR_W-1:0] r_f_addr;
    logic              r_busy;

    logic              w_any;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fill;
    logic              w_hit;
    logic [31:0]       w_cache_data;

    assign w_any  = io_bus.m0_valid || io_bus.m1_valid;
    assign w_gnt  = pick_port(io_bus.m0_valid, io_bus.m1_valid, r_rr_ptr, r_rr_seen);
    assign w_addr = (w_gnt == PORT_STREAM) ? io_bus.m1_addr : io_bus.m0_addr;
    assign w_fill = (r_state == ST_FETCH) && io_bus.f_ready;

    if (CACHE_EN) begin : g_cache
        spiflash_lastword #(
            .ADDR_W (ADDR_W)
        ) u_lastword (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_fill        (w_fill),
            .i_inv         (i_inv),
            .i_inv_pend    (r_inv_pend),
            .i_fill_addr   (r_addr),
            .i_fill_data   (io_bus.f_rdata),
            .i_lookup_addr (w_addr),
            .o_hit         (w_hit),
            .o_data        (w_cache_data)
        );
    end else begin : g_nocache
        assign w_hit        = 1'b0;
        assign w_cache_data = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= PORT_CPU;
            r_addr     <= '0;
            r_rr_ptr   <= PORT_CPU;
            r_rr_seen  <= 1'b0;
            r_inv_pend <= 1'b0;
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_f_valid  <= 1'b0;
            r_f_addr   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_gnt;
                        r_addr <= w_addr;
                        r_busy <= 1'b1;
                        if (w_hit) begin
                            r_state <= ST_RESP;
                            if (w_gnt == PORT_STREAM) begin
                                r_m1_ready <= 1'b1;
                                r_m1_rdata <= w_cache_data;
                            end else begin
                                r_m0_ready <= 1'b1;
                                r_m0_rdata <= w_cache_data;
                            end
                        end else begin
                            r_state   <= ST_FETCH;
                            r_f_valid <= 1'b1;
                            r_f_addr  <= w_addr;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_inv) begin
                        r_inv_pend <= 1'b1;
                    end
                    // Drop valid on the completing edge; the reader re-triggers on valid && !ready.
                    if (io_bus.f_ready) begin
                        r_f_valid  <= 1'b0;
                        r_inv_pend <= 1'b0;
                        r_state    <= ST_RESP;
                        if (r_gnt == PORT_STREAM) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= io_bus.f_rdata;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= io_bus.f_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    r_rr_ptr  <= r_gnt;
                    r_rr_seen <= 1'b1;
                    r_state   <= ST_GAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.m0_ready = r_m0_ready;
    assign io_bus.m0_rdata = r_m0_rdata;
    assign io_bus.m1_ready = r_m1_ready;
    assign io_bus.m1_rdata = r_m1_rdata;
    assign io_bus.f_valid  = r_f_valid;
    assign io_bus.f_addr   = r_f_addr;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_spiflash_arb.sv
// Directed bench: cached and uncached arbiters, each behind a fixed-latency flash reader model.
module tb_spiflash_arb;

    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inv0 = 1'b0;
    logic inv1 = 1'b0;
    logic busy0;
    logic busy1;
    int   lat = 80;
    int   fetches0 = 0;
    int   fetches1 = 0;
    int   errors = 0;
    int   checks = 0;

    spiflash_arb_if #(.ADDR_W(AW)) b0 ();
    spiflash_arb_if #(.ADDR_W(AW)) b1 ();

    spiflash_arb #(.ADDR_W(AW), .CACHE_EN(1'b1)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_inv(inv0), .o_busy(busy0), .io_bus(b0.slave)
    );
    spiflash_arb #(.ADDR_W(AW), .CACHE_EN(1'b0)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_inv(inv1), .o_busy(busy1), .io_bus(b1.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flash_word(input logic [AW-1:0] a);
        return (a == 24'h000100) ? 32'h11223344 : {8'hA5, a};
    endfunction

    // Flash reader models: start on valid && !ready, answer after lat cycles.
    logic act0, act1;
    int   cnt0, cnt1;

    always @(posedge clk) begin
        if (rst) begin
            act0 <= 1'b0; cnt0 <= 0; b0.f_ready <= 1'b0; b0.f_rdata <= '0;
        end else begin
            b0.f_ready <= 1'b0;
            if (!act0) begin
                if (b0.f_valid && !b0.f_ready) begin
                    act0 <= 1'b1; cnt0 <= lat; fetches0 <= fetches0 + 1;
                end
            end else if (cnt0 <= 1) begin
                act0 <= 1'b0; b0.f_ready <= 1'b1; b0.f_rdata <= flash_word(b0.f_addr);
            end else begin
                cnt0 <= cnt0 - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            act1 <= 1'b0; cnt1 <= 0; b1.f_ready <= 1'b0; b1.f_rdata <= '0;
        end else begin
            b1.f_ready <= 1'b0;
            if (!act1) begin
                if (b1.f_valid && !b1.f_ready) begin
                    act1 <= 1'b1; cnt1 <= lat; fetches1 <= fetches1 + 1;
                end
            end else if (cnt1 <= 1) begin
                act1 <= 1'b0; b1.f_ready <= 1'b1; b1.f_rdata <= flash_word(b1.f_addr);
            end else begin
                cnt1 <= cnt1 - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit d, input bit p, input logic v, input logic [AW-1:0] a);
        if (!d && !p) begin b0.m0_valid = v; b0.m0_addr = a; end
        if (!d && p)  begin b0.m1_valid = v; b0.m1_addr = a; end
        if (d && !p)  begin b1.m0_valid = v; b1.m0_addr = a; end
        if (d && p)   begin b1.m1_valid = v; b1.m1_addr = a; end
    endtask

    task automatic set_inv(input bit d, input logic v);
        if (d) inv1 = v;
        else   inv0 = v;
    endtask

    function automatic logic get_ready(input bit d, input bit p);
        if (d) return p ? b1.m1_ready : b1.m0_ready;
        return p ? b0.m1_ready : b0.m0_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit d, input bit p);
        if (d) return p ? b1.m1_rdata : b1.m0_rdata;
        return p ? b0.m1_rdata : b0.m0_rdata;
    endfunction

    // One read on port p of DUT d; cycle 0 is the IDLE cycle where valid is first seen.
    task automatic read_txn(input bit d, input bit p, input logic [AW-1:0] a, input int inv_at,
                            output int t_fv, output logic [AW-1:0] fa, output int t_fr,
                            output int t_rdy, output logic [31:0] data, output int busy_n,
                            output int rdy_n, output logic fv_after);
        t_fv = -1; fa = '0; t_fr = -1; t_rdy = -1; data = '0; busy_n = 0; rdy_n = 0;
        fv_after = 1'b1;
        set_req(d, p, 1'b1, a);
        set_inv(d, inv_at == 0);
        for (int n = 1; n <= 400; n++) begin
            tick();
            set_inv(d, n == inv_at);
            if ((d ? b1.f_valid : b0.f_valid) && t_fv < 0) begin
                t_fv = n;
                fa = d ? b1.f_addr : b0.f_addr;
            end
            if (d ? busy1 : busy0) busy_n++;
            if ((d ? b1.f_ready : b0.f_ready) && t_fr < 0) t_fr = n;
            if (t_fr >= 0 && n == t_fr + 1) fv_after = d ? b1.f_valid : b0.f_valid;
            if (get_ready(d, p)) begin
                rdy_n++;
                if (t_rdy < 0) begin
                    t_rdy = n;
                    data = get_rdata(d, p);
                end
            end
            if (t_rdy >= 0 && n == t_rdy + 1) set_req(d, p, 1'b0, a);
            if (t_rdy >= 0 && n == t_rdy + 3) break;
        end
        set_req(d, p, 1'b0, a);
        set_inv(d, 1'b0);
    endtask

    // Both ports of DUT 0 request together; records service order and returned data.
    task automatic tie_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            output int first, output int second,
                            output logic [31:0] d0, output logic [31:0] d1);
        int drop0, drop1;
        first = -1; second = -1; d0 = '0; d1 = '0; drop0 = -1; drop1 = -1;
        set_req(0, 0, 1'b1, a0);
        set_req(0, 1, 1'b1, a1);
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (b0.m0_ready && drop0 < 0) begin
                d0 = b0.m0_rdata; drop0 = n + 1;
                if (first < 0) first = 0; else second = 0;
            end
            if (b0.m1_ready && drop1 < 0) begin
                d1 = b0.m1_rdata; drop1 = n + 1;
                if (first < 0) first = 1; else second = 1;
            end
            if (n == drop0) set_req(0, 0, 1'b0, a0);
            if (n == drop1) set_req(0, 1, 1'b0, a1);
            if (drop0 >= 0 && drop1 >= 0 && n >= drop0 + 2 && n >= drop1 + 2) break;
        end
        set_req(0, 0, 1'b0, a0);
        set_req(0, 1, 1'b0, a1);
    endtask

    initial begin
        int t_fv, t_fr, t_rdy, busy_n, rdy_n, first, second, f_before;
        logic [AW-1:0] fa;
        logic [31:0] data, d0, d1;
        logic fv_after;

        set_req(0, 0, 1'b0, '0); set_req(0, 1, 1'b0, '0);
        set_req(1, 0, 1'b0, '0); set_req(1, 1, 1'b0, '0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_busy", busy0, 1'b0);
        check("rst_f_valid", b0.f_valid, 1'b0);
        check("rst_f_addr", b0.f_addr, 24'h0);
        check("rst_ready", {b0.m0_ready, b0.m1_ready}, 2'b00);
        check("rst_rdata", {b0.m0_rdata, b0.m1_rdata}, 64'h0);

        // Cold miss with a slow flash.
        lat = 80;
        read_txn(0, 0, 24'h000100, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("miss_fv_cycle", t_fv, 1);
        check("miss_f_addr", fa, 24'h000100);
        check("miss_slow", t_fr > 80, 1'b1);
        check("miss_rdy_after_fr", t_rdy, t_fr + 1);
        check("miss_fv_drop", fv_after, 1'b0);
        check("miss_data", data, 32'h11223344);
        check("miss_one_pulse", rdy_n, 1);

        // Same address again hits the last-word cache.
        lat = 20;
        f_before = fetches0;
        read_txn(0, 0, 24'h000100, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("hit_rdy_cycle", t_rdy, 1);
        check("hit_no_fv", t_fv, -1);
        check("hit_data", data, 32'h11223344);
        check("hit_busy_cycles", busy_n, 2);
        check("hit_no_fetch", fetches0, f_before);

        // Simultaneous requests right after reset, then a second tie.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tie_pair(24'h000010, 24'h000020, first, second, d0, d1);
        check("tie1_first", first, 0);
        check("tie1_second", second, 1);
        check("tie1_d0", d0, 32'hA5000010);
        check("tie1_d1", d1, 32'hA5000020);
        tie_pair(24'h000010, 24'h000020, first, second, d0, d1);
        check("tie2_first", first, 0);
        check("tie2_second", second, 1);

        // Invalidate mid-fetch blocks the fill.
        read_txn(0, 0, 24'h000040, 10, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("inv_fetch_data", data, 32'hA5000040);
        check("inv_inside_fetch", t_fr > 10, 1'b1);
        read_txn(0, 0, 24'h000040, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("inv_reread_miss", t_fv, 1);
        read_txn(0, 1, 24'h000040, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("refill_hit_p1", t_fv, -1);
        check("refill_hit_rdy", t_rdy, 1);
        read_txn(0, 0, 24'h000040, 0, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("inv_same_cycle_miss", t_fv, 1);

        // Reset in the middle of a fetch.
        set_req(0, 0, 1'b1, 24'h000080);
        repeat (5) tick();
        check("pre_rst_fv", b0.f_valid, 1'b1);
        rst = 1'b1;
        set_req(0, 0, 1'b0, 24'h000080);
        tick();
        check("mid_rst_fv", b0.f_valid, 1'b0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_ready", {b0.m0_ready, b0.m1_ready}, 2'b00);
        rst = 1'b0;
        tick();
        read_txn(0, 0, 24'h000100, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("post_rst_miss", t_fv, 1);
        check("post_rst_data", data, 32'h11223344);

        // Cache disabled: every read goes to flash.
        read_txn(1, 0, 24'h000100, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("nc_first_fv", t_fv, 1);
        check("nc_first_data", data, 32'h11223344);
        read_txn(1, 0, 24'h000100, -1, t_fv, fa, t_fr, t_rdy, data, busy_n, rdy_n, fv_after);
        check("nc_second_fv", t_fv, 1);
        check("nc_second_data", data, 32'h11223344);
        check("nc_fetch_count", fetches1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spiflash_arb.md
Name: spiflash_arb

Overview:
- Two-port arbiter and sequencer in front of the read-only SPI flash reader (`spiflashro`).
- Shares the single flash word-read datapath between port 0 (CPU fetch) and port 1 (sample streamer feeding the DAC).
- Round-robin grant; drives the flash valid/ready handshake with correct drop timing.
- Holds a one-entry last-word cache so repeated reads of the same address skip the SPI transaction.

Parameters:
- ADDR_W, 24, byte address width; matches the flash reader address port.
- CACHE_EN, 1, 1 = last-word cache enabled; 0 = every request goes to flash.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  port 0 request; held high until m0_ready, dropped the cycle after
- m0_addr  in  ADDR_W  port 0 byte address; stable while m0_valid is high
- m0_rdata  out  32  port 0 read data; valid only while m0_ready is high
- m0_ready  out  1  port 0 one-cycle completion pulse
- m1_valid, m1_addr, m1_rdata, m1_ready  same directions, widths and rules as port 0
- inv  in  1  single-cycle cache invalidate pulse
- f_valid  out  1  request to the flash reader
- f_addr  out  ADDR_W  address to the flash reader
- f_rdata  in  32  word from the flash reader
- f_ready  in  1  one-cycle completion pulse from the flash reader
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: m*_ready=0, m*_rdata=0, f_valid=0, f_addr=0, busy=0, state=IDLE, rr_ptr=0, cache_vld=0, inv_pend=0.
- Reset asserted mid-fetch: reset values apply on the next edge. The flash reader shares the same reset.
- States:
  - IDLE: arbitrate among asserted m*_valid.
    - Single requester: grant it.
    - Both requesting: grant the port ≠ rr_ptr; rr_ptr=0 after reset, so port 0 wins the first tie.
    - Latch the granted port and its address.
    - Hit (CACHE_EN && cache_vld && addr==cache_addr && !inv): go to RESP, data from the cache.
    - Otherwise go to FETCH with f_valid<=1 and f_addr<=addr.
  - FETCH: hold f_valid and f_addr. On f_ready=1: f_valid<=0 on the same edge, capture f_rdata, go to RESP.
    - Dropping f_valid on that edge prevents the flash reader from restarting, since it re-triggers on valid && !ready.
  - RESP: granted m*_ready=1 with m*_rdata for exactly one cycle; rr_ptr<=granted port; go to GAP.
  - GAP: one dead cycle with no arbitration, so the served requester can drop valid; go to IDLE.
- Latency, with cycle 0 = IDLE sampling valid:
  - Hit: ready in cycle 1; next grant no earlier than cycle 3.
  - Miss: f_valid high from cycle 1; ready one cycle after f_ready.
- Cache fill: on f_ready, store cache_addr/cache_data and set cache_vld, unless inv is high that cycle or inv_pend is set.
- inv:
  - Clears cache_vld immediately.
  - If it arrives during FETCH, set inv_pend; inv_pend clears on leaving FETCH.
  - inv in the same IDLE cycle as a matching request forces a miss.
- The ungranted port's valid is ignored until IDLE; the losing requester keeps holding.
- Address is compared over the full ADDR_W bits, with no word alignment applied. f_rdata is passed through unmodified (byte order is the flash reader's concern).
- CACHE_EN=0: cache_vld is held at 0 and the cache registers are not built.

Decomposition:
- Package spiflash_arb_pkg:
  - state encoding localparams ST_IDLE, ST_FETCH, ST_RESP, ST_GAP (2 bits);
  - port index constants PORT_CPU=0, PORT_STREAM=1.
- One sub-module: spiflash_lastword, the cache entry. Inputs: fill, inv, inv_pend, lookup address. Outputs: hit, data. Generated only when CACHE_EN=1.

Test Plan:
- Reset, then m0 reads 0x000100; the flash model returns 0x11223344 after 80 cycles. Required: f_valid high from cycle 1 and low the cycle after f_ready; m0_ready pulses once with 0x11223344.
- m0 re-reads 0x000100. Required: m0_ready at cycle 1 with 0x11223344, no f_valid assertion, busy high for 2 cycles.
- m0 and m1 request on the same cycle right after reset (0x10, 0x20). Required: m0 served first, then m1. A further simultaneous pair is served m0 then m1 again, because rr_ptr=1 after m1 is served.
- Pulse inv 10 cycles into a fetch of 0x40, then re-read 0x40. Required: the second read issues f_valid, i.e. it is not cached.
- Assert reset while in FETCH. Required: next cycle f_valid=0, busy=0, no m*_ready. A subsequent read of 0x000100 misses.
- CACHE_EN=0, two reads of the same address. Required: both issue f_valid.
